// File: rtl/ex_mem_flag_stage.sv
// ex_mem_flag_stage: EX->MEM pipeline register for the 16-bit core.
// It owns the architectural ov/zr/ne flags, feeds them back to the ALU,
// resolves conditional branches in EX, and registers the ALU result and
// control for MEM one cycle later.
// Optional feature macro: EXM_PERF_CNT_EN enables the saturating
// taken-branch and overflow-event counters. With the macro undefined the
// counter outputs read 0 and cnt_clr is ignored.
module ex_mem_flag_stage #(
  parameter int DW    = 16,
  parameter int RW    = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_EX,
  input  logic [DW-1:0]    alu_result,
  input  logic             ov,
  input  logic             zr,
  input  logic             ne,
  input  logic             flag_we,
  input  logic             br_EX,
  input  logic [2:0]       cond,
  input  logic [DW-1:0]    br_target,
  input  logic [RW-1:0]    dst_EX,
  input  logic             rf_we_EX,
  input  logic             mem_re_EX,
  input  logic             mem_we_EX,
  input  logic [DW-1:0]    st_data_EX,
  output logic             ov_EX,
  output logic             zr_EX,
  output logic             ne_EX,
  output logic             br_taken,
  output logic [DW-1:0]    br_pc,
  output logic             valid_MEM,
  output logic [DW-1:0]    result_MEM,
  output logic [RW-1:0]    dst_MEM,
  output logic             rf_we_MEM,
  output logic             mem_re_MEM,
  output logic             mem_we_MEM,
  output logic [DW-1:0]    st_data_MEM,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] ov_cnt,
  input  logic             cnt_clr
);

  logic       advance;
  logic       flag_upd;
  logic [2:0] flags_reg;   // {ov, zr, ne}
  logic       cond_true;

  // Flush beats stall; only a clean cycle moves EX into MEM.
  assign advance  = ~stall & ~flush;
  assign flag_upd = advance & valid_EX & flag_we;

  assign ov_EX = flags_reg[2];
  assign zr_EX = flags_reg[1];
  assign ne_EX = flags_reg[0];

  // Architectural flags: latched only when a real flag-setting op retires from EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_reg <= 3'b000;
    end else if (flag_upd) begin
      flags_reg <= {ov, zr, ne};
    end
  end

  // Branch condition decode on the registered flags.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000:  cond_true = ~zr_EX;
      3'b001:  cond_true = zr_EX;
      3'b010:  cond_true = ~zr_EX & ~ne_EX;
      3'b011:  cond_true = ne_EX;
      3'b100:  cond_true = zr_EX | ~ne_EX;
      3'b101:  cond_true = zr_EX | ne_EX;
      3'b110:  cond_true = ov_EX;
      default: cond_true = 1'b1;
    endcase
  end

  // Redirect is suppressed during stall so a held branch redirects only once;
  // reset masks it so every output reads 0 while rst is high.
  assign br_taken = ~rst & valid_EX & br_EX & advance & cond_true;
  assign br_pc    = rst ? '0 : br_target;

  // MEM pipeline registers: flush inserts a bubble, stall holds, advance loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_MEM   <= 1'b0;
      result_MEM  <= '0;
      dst_MEM     <= '0;
      rf_we_MEM   <= 1'b0;
      mem_re_MEM  <= 1'b0;
      mem_we_MEM  <= 1'b0;
      st_data_MEM <= '0;
    end else if (flush) begin
      // Data fields are don't-care in a bubble and simply hold.
      valid_MEM  <= 1'b0;
      rf_we_MEM  <= 1'b0;
      mem_re_MEM <= 1'b0;
      mem_we_MEM <= 1'b0;
    end else if (!stall) begin
      valid_MEM   <= valid_EX;
      result_MEM  <= alu_result;
      dst_MEM     <= dst_EX;
      rf_we_MEM   <= rf_we_EX & valid_EX;
      mem_re_MEM  <= mem_re_EX & valid_EX;
      mem_we_MEM  <= mem_we_EX & valid_EX;
      st_data_MEM <= st_data_EX;
    end
  end

`ifdef EXM_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] br_cnt_reg;
  logic [CNT_W-1:0] ov_cnt_reg;

  // Saturating event counters; a clear in the same cycle wins over an increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_reg <= '0;
      ov_cnt_reg <= '0;
    end else if (cnt_clr) begin
      br_cnt_reg <= '0;
      ov_cnt_reg <= '0;
    end else begin
      if (br_taken && (br_cnt_reg != '1)) begin
        br_cnt_reg <= br_cnt_reg + CNT_ONE;
      end
      if (flag_upd && ov && (ov_cnt_reg != '1)) begin
        ov_cnt_reg <= ov_cnt_reg + CNT_ONE;
      end
    end
  end

  assign br_cnt = br_cnt_reg;
  assign ov_cnt = ov_cnt_reg;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign br_cnt         = '0;
  assign ov_cnt         = '0;
`endif

endmodule
